// File: rtl/spixel_draw_arbiter_if.sv
// Request/draw bundle between requesters, arbiter and draw_superpixel.
// master: game logic + engine side; slave: the arbiter.
interface spixel_draw_arbiter_if #(
   parameter int NUM_REQ        = 3,
   parameter int SPIXEL_X_WIDTH = 5,
   parameter int SPIXEL_Y_WIDTH = 5,
   parameter int COLOR_ID_WIDTH = 8
);
   localparam int GRANT_WIDTH =
      (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]                req_vld;
   logic [NUM_REQ*SPIXEL_X_WIDTH-1:0] req_x;
   logic [NUM_REQ*SPIXEL_Y_WIDTH-1:0] req_y;
   logic [NUM_REQ*COLOR_ID_WIDTH-1:0] req_color;
   logic [NUM_REQ-1:0]                req_ack;
   logic                              req_err;
   logic [SPIXEL_X_WIDTH-1:0]         ox;
   logic [SPIXEL_Y_WIDTH-1:0]         oy;
   logic [COLOR_ID_WIDTH-1:0]         odata;
   logic                              odata_vld;
   logic                              idone;
   logic                              busy;
   logic [GRANT_WIDTH-1:0]            grant_id;

   modport master (
      output req_vld,
      output req_x,
      output req_y,
      output req_color,
      output idone,
      input  req_ack,
      input  req_err,
      input  ox,
      input  oy,
      input  odata,
      input  odata_vld,
      input  busy,
      input  grant_id
   );

   modport slave (
      input  req_vld,
      input  req_x,
      input  req_y,
      input  req_color,
      input  idone,
      output req_ack,
      output req_err,
      output ox,
      output oy,
      output odata,
      output odata_vld,
      output busy,
      output grant_id
   );
endinterface

// File: rtl/spixel_draw_arbiter.sv
// Round-robin arbiter sharing one draw_superpixel engine.
// Ports: clk, rst (async high), bus (slave: requests in, draw/ack out).
module spixel_draw_arbiter #(
   parameter int NUM_REQ        = 3,
   parameter int SPIXEL_X_WIDTH = 5,
   parameter int SPIXEL_Y_WIDTH = 5,
   parameter int COLOR_ID_WIDTH = 8,
   parameter int TIMEOUT_WIDTH  = 10,
   parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_MAX = 10'd1023
) (
   input logic                 clk,
   input logic                 rst,
   spixel_draw_arbiter_if.slave bus
);
   localparam int GW =
      (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [NUM_REQ-1:0] ONE = 1;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } state_t;

   state_t                     state;
   logic [GW-1:0]              ptr;
   logic [GW-1:0]              gid;
   logic [TIMEOUT_WIDTH-1:0]   cnt;
   logic [TIMEOUT_WIDTH:0]     cnt_inc;
   logic                       timeout;
   logic                       pick_vld;
   logic [GW-1:0]              pick_id;
   logic [GW-1:0]              idx;
   logic [GW-1:0]              ptr_nxt;
   logic [SPIXEL_X_WIDTH-1:0]  ox_q;
   logic [SPIXEL_Y_WIDTH-1:0]  oy_q;
   logic [COLOR_ID_WIDTH-1:0]  odata_q;
   logic                       vld_q;
   logic [NUM_REQ-1:0]         ack_q;
   logic                       err_q;
   logic                       busy_q;

   function automatic logic [GW-1:0] wrap_add(
      input logic [GW-1:0] base,
      input int            k
   );
      int s;
      s = int'(base) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return GW'(s);
   endfunction

   // Scan from the highest offset down so the
   // lowest offset from ptr is the one that sticks.
   always_comb begin
      pick_vld = 1'b0;
      pick_id  = '0;
      idx      = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = wrap_add(ptr, k);
         if (bus.req_vld[idx]) begin
            pick_vld = 1'b1;
            pick_id  = idx;
         end
      end
   end

   assign ptr_nxt = (gid == GW'(NUM_REQ - 1))
                  ? '0 : gid + 1'b1;

   // cnt_inc counts the current WAIT cycle, so the
   // give-up happens on WAIT cycle TIMEOUT_MAX.
   assign cnt_inc = {1'b0, cnt} + 1'b1;
   assign timeout = cnt_inc >= {1'b0, TIMEOUT_MAX};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         ptr     <= '0;
         gid     <= '0;
         cnt     <= '0;
         ox_q    <= '0;
         oy_q    <= '0;
         odata_q <= '0;
         vld_q   <= 1'b0;
         ack_q   <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         vld_q <= 1'b0;
         ack_q <= '0;
         err_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (pick_vld) begin
                  gid     <= pick_id;
                  ox_q    <= bus.req_x[pick_id*SPIXEL_X_WIDTH
                                       +: SPIXEL_X_WIDTH];
                  oy_q    <= bus.req_y[pick_id*SPIXEL_Y_WIDTH
                                       +: SPIXEL_Y_WIDTH];
                  odata_q <= bus.req_color[pick_id*COLOR_ID_WIDTH
                                           +: COLOR_ID_WIDTH];
                  vld_q   <= 1'b1;
                  busy_q  <= 1'b1;
                  state   <= ISSUE;
               end
            end
            ISSUE: begin
               cnt   <= '0;
               state <= WAIT;
            end
            WAIT: begin
               if (bus.idone) begin
                  ack_q <= ONE << gid;
                  err_q <= 1'b0;
                  state <= DONE;
               end else if (timeout) begin
                  ack_q <= ONE << gid;
                  err_q <= 1'b1;
                  state <= DONE;
               end else begin
                  cnt <= cnt_inc[TIMEOUT_WIDTH-1:0];
               end
            end
            DONE: begin
               ptr    <= ptr_nxt;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.ox        = ox_q;
   assign bus.oy        = oy_q;
   assign bus.odata     = odata_q;
   assign bus.odata_vld = vld_q;
   assign bus.req_ack   = ack_q;
   assign bus.req_err   = err_q;
   assign bus.busy      = busy_q;
   assign bus.grant_id  = gid;
endmodule

// File: tb/tb_spixel_draw_arbiter.sv
// Self-checking bench for spixel_draw_arbiter.
// Timeline reference model plus directed and random stimulus.
module tb_spixel_draw_arbiter;
   localparam int N  = 3;
   localparam int XW = 5;
   localparam int YW = 5;
   localparam int CW = 8;
   localparam int TMAX = 20;

   logic clk = 1'b0;
   logic rst = 1'b1;

   spixel_draw_arbiter_if #(
      .NUM_REQ(N), .SPIXEL_X_WIDTH(XW),
      .SPIXEL_Y_WIDTH(YW), .COLOR_ID_WIDTH(CW)
   ) bus ();

   spixel_draw_arbiter #(
      .NUM_REQ(N), .SPIXEL_X_WIDTH(XW),
      .SPIXEL_Y_WIDTH(YW), .COLOR_ID_WIDTH(CW),
      .TIMEOUT_WIDTH(10), .TIMEOUT_MAX(10'd20)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
      end
   endtask

   // stimulus controls (owned by main)
   int        req_cnt[N];
   logic [XW-1:0] tx[N];
   logic [YW-1:0] ty[N];
   logic [CW-1:0] tc[N];
   bit        rand_mode = 0;
   int        eng_lat = 5;
   int        stray_cnt = 0;
   logic [N-1:0] rst_vld = '0;

   // requester side state
   int        issued[N];
   int        raise_cyc[N];
   // engine side state
   int        ecnt = -1;
   int        lat = 0;
   int        stray_done = 0;

   // model and logs
   int        cyc = 0;
   bit        m_active;
   int        m_age, m_done_at, m_ptr, m_win;
   bit        m_err;
   logic [XW-1:0] m_x;
   logic [YW-1:0] m_y;
   logic [CW-1:0] m_c;
   int        grant_log[$];
   int        strobe_cyc, ack_cyc, ack_count = 0;
   logic      ack_err;
   logic [XW-1:0] s_x;
   logic [YW-1:0] s_y;
   logic [CW-1:0] s_c;

   initial begin
      for (int i = 0; i < N; i++) begin
         req_cnt[i] = 0; issued[i] = 0; raise_cyc[i] = 0;
         tx[i] = '0; ty[i] = '0; tc[i] = '0;
      end
      bus.req_vld = '0;
      bus.req_x = '0;
      bus.req_y = '0;
      bus.req_color = '0;
      bus.idone = 1'b0;
   end

   // requesters: hold req_vld until ack
   always @(negedge clk) begin
      if (rst) begin
         bus.req_vld = rst_vld;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (bus.req_ack[i]) begin
               bus.req_vld[i] = 1'b0;
            end else if (!bus.req_vld[i]) begin
               if (issued[i] < req_cnt[i]) begin
                  bus.req_vld[i] = 1'b1;
                  issued[i]++;
                  raise_cyc[i] = cyc;
               end else if (rand_mode &&
                            $urandom_range(0, 4) == 0) begin
                  bus.req_vld[i] = 1'b1;
               end
            end
         end
      end
      for (int i = 0; i < N; i++) begin
         bus.req_x[i*XW +: XW] =
            rand_mode ? XW'($urandom) : tx[i];
         bus.req_y[i*YW +: YW] =
            rand_mode ? YW'($urandom) : ty[i];
         bus.req_color[i*CW +: CW] =
            rand_mode ? CW'($urandom) : tc[i];
      end
   end

   // engine: idone lat cycles after the strobe
   always @(negedge clk) begin
      bus.idone = 1'b0;
      if (rst) begin
         ecnt = -1;
      end else begin
         if (bus.odata_vld) begin
            ecnt = 0;
            if (rand_mode)
               lat = ($urandom_range(0, 9) == 0)
                   ? -1 : int'($urandom_range(0, 24));
            else
               lat = eng_lat;
         end else if (ecnt >= 0) begin
            ecnt++;
         end
         if (ecnt >= 0 && lat >= 0 && ecnt == lat) begin
            bus.idone = 1'b1;
            ecnt = -1;
         end
         if (stray_cnt != stray_done) begin
            bus.idone = 1'b1;
            stray_done++;
         end
         if (rand_mode && $urandom_range(0, 15) == 0)
            bus.idone = 1'b1;
      end
   end

   // reference model: per-transaction timeline
   // age 1 = strobe, age>=2 = waiting, age done_at = ack
   always @(posedge clk) begin
      logic [N-1:0] exp_ack;
      bit found;
      int j;
      cyc++;
      if (rst) begin
         m_active = 0; m_age = 0; m_done_at = 0;
         m_ptr = 0; m_win = 0; m_err = 0;
         m_x = '0; m_y = '0; m_c = '0;
      end else if (m_active) begin
         if (m_age == m_done_at) begin
            m_active = 0;
            m_ptr = (m_win + 1) % N;
         end else begin
            if (m_done_at == 0 && m_age >= 2) begin
               if (bus.idone) begin
                  m_done_at = m_age + 1; m_err = 0;
               end else if (m_age - 1 >= TMAX) begin
                  m_done_at = m_age + 1; m_err = 1;
               end
            end
            m_age++;
         end
      end else begin
         found = 0;
         for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (!found && bus.req_vld[j]) begin
               found = 1;
               m_win = j;
            end
         end
         if (found) begin
            m_active = 1; m_age = 1; m_done_at = 0;
            m_x = bus.req_x[m_win*XW +: XW];
            m_y = bus.req_y[m_win*YW +: YW];
            m_c = bus.req_color[m_win*CW +: CW];
         end
      end
      #1;
      if (!rst) begin
         exp_ack = (m_active && m_age == m_done_at)
                 ? N'(1 << m_win) : '0;
         chk("busy", bus.busy, m_active);
         chk("odata_vld", bus.odata_vld,
             m_active && m_age == 1);
         chk("req_ack", bus.req_ack, exp_ack);
         chk("req_err", bus.req_err,
             (exp_ack != 0) ? m_err : 1'b0);
         chk("ox", bus.ox, m_x);
         chk("oy", bus.oy, m_y);
         chk("odata", bus.odata, m_c);
         chk("grant_id", bus.grant_id, m_win);
         if (bus.odata_vld) begin
            grant_log.push_back(int'(bus.grant_id));
            strobe_cyc = cyc;
            s_x = bus.ox; s_y = bus.oy; s_c = bus.odata;
         end
         if (|bus.req_ack) begin
            ack_cyc = cyc;
            ack_err = bus.req_err;
            ack_count++;
         end
      end
   end

   task automatic wait_acks(input int n, input int budget,
                            input string name);
      int target;
      target = ack_count + n;
      for (int t = 0; t < budget && ack_count < target; t++)
         @(posedge clk);
      #2;
      chk(name, ack_count >= target, 1);
   endtask

   task automatic check_all_zero(input string name);
      chk({name, "_busy"}, bus.busy, 0);
      chk({name, "_vld"}, bus.odata_vld, 0);
      chk({name, "_ack"}, bus.req_ack, 0);
      chk({name, "_err"}, bus.req_err, 0);
      chk({name, "_ox"}, bus.ox, 0);
      chk({name, "_oy"}, bus.oy, 0);
      chk({name, "_odata"}, bus.odata, 0);
      chk({name, "_gid"}, bus.grant_id, 0);
   endtask

   initial begin
      int d;
      int rr_exp[6];
      rr_exp = '{0, 2, 0, 2, 0, 2};
      repeat (2) @(posedge clk);
      #1 check_all_zero("reset");
      @(negedge clk) rst = 1'b0;

      // simultaneous requests from reset: 0,1,2
      grant_log.delete();
      eng_lat = 5;
      for (int i = 0; i < N; i++) req_cnt[i]++;
      wait_acks(3, 200, "simul_done");
      chk("simul_n", grant_log.size(), 3);
      for (int i = 0; i < 3 && i < grant_log.size(); i++)
         chk("simul_order", grant_log[i], i);

      // round robin: 0 and 2 keep re-requesting
      grant_log.delete();
      req_cnt[0] += 3;
      req_cnt[2] += 3;
      wait_acks(6, 400, "rr_done");
      chk("rr_n", grant_log.size(), 6);
      for (int i = 0; i < 6 && i < grant_log.size(); i++)
         chk("rr_order", grant_log[i], rr_exp[i]);

      // single request with literal payload
      tx[0] = 5'd7; ty[0] = 5'd3; tc[0] = 8'hff;
      eng_lat = 10;
      req_cnt[0]++;
      wait_acks(1, 100, "single_done");
      chk("single_lat", strobe_cyc - raise_cyc[0], 1);
      chk("single_ox", s_x, 7);
      chk("single_oy", s_y, 3);
      chk("single_odata", s_c, 8'hff);
      chk("single_ackdly", ack_cyc - strobe_cyc, 11);
      chk("single_err", ack_err, 0);
      repeat (2) @(posedge clk);
      #2 chk("single_idle", bus.busy, 0);

      // timeout, then done on the last wait cycle
      eng_lat = -1;
      req_cnt[1]++;
      wait_acks(1, 100, "to_done");
      chk("to_dly", ack_cyc - strobe_cyc, 21);
      chk("to_err", ack_err, 1);
      eng_lat = 20;
      req_cnt[1]++;
      wait_acks(1, 100, "to20_done");
      chk("to20_dly", ack_cyc - strobe_cyc, 21);
      chk("to20_err", ack_err, 0);

      // stray done in idle is ignored
      @(negedge clk);
      d = ack_count;
      stray_cnt++;
      repeat (4) @(posedge clk);
      #2 chk("stray_noack", ack_count - d, 0);
      eng_lat = 8;
      req_cnt[2]++;
      wait_acks(1, 100, "stray_done");
      chk("stray_dly", ack_cyc - strobe_cyc, 9);
      chk("stray_err", ack_err, 0);

      // async reset in the middle of WAIT
      eng_lat = -1;
      req_cnt[0]++;
      repeat (8) @(posedge clk);
      chk("mid_busy", bus.busy, 1);
      #3;
      rst_vld = 3'b110;
      rst = 1'b1;
      #1 check_all_zero("async_rst");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      grant_log.delete();
      eng_lat = 4;
      wait_acks(2, 100, "post_rst_done");
      chk("post_rst_n", grant_log.size(), 2);
      if (grant_log.size() >= 2) begin
         chk("post_rst_first", grant_log[0], 1);
         chk("post_rst_second", grant_log[1], 2);
      end

      // random traffic against the model
      rand_mode = 1;
      repeat (4000) @(posedge clk);
      @(negedge clk);
      rand_mode = 0;
      eng_lat = 3;
      repeat (200) @(posedge clk);
      #2;
      chk("drain_busy", bus.busy, 0);
      chk("drain_vld", bus.req_vld, 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: run did not end, errors %0d",
               errors);
      $fatal(1, "watchdog");
   end
endmodule
